// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the pixel FIFO write arbiter: FSM encoding,
// credit counter sizing and statistics counter width.
package fifo_arb_pkg;

    localparam int STAT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } arb_state_t;

    // Width needed to hold 0..depth-1 free slots with headroom for the full range.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first eligible requester at or
// after rr_ptr, wrapping around, and reports it as one-hot and as an index.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx,
    output logic          any_valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan every offset from rr_ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned, which would infer a latch.
        winner     = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(off);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!any_valid && eligible[idx]) begin
                any_valid   = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the pixel FIFO write port among the Mandelbrot
// workers. A credit counter mirrors free FIFO slots (including writes still
// in flight) so a write is never issued into a full FIFO; credits are
// returned by tapping the VGA-side read strobe.
// Optional build macro: ARB_STATS_EN adds stall and per-worker grant counters.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_WORKERS = 4,
    parameter int BIT_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [NUM_WORKERS-1:0]             wrk_req,
    input  logic [NUM_WORKERS*BIT_WIDTH-1:0]   wrk_data,
    output logic [NUM_WORKERS-1:0]             wrk_ack,
    output logic                               fifo_w_cntrl,
    output logic [BIT_WIDTH-1:0]               fifo_data_in,
    input  logic                               fifo_r_cntrl,
    input  logic                               fifo_empty,
    output logic [credit_width(FIFO_DEPTH)-1:0] credits,
    output logic                               busy
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]              stall_cycles,
    output logic [NUM_WORKERS*STAT_WIDTH-1:0]  grant_cnt
`endif
);

    localparam int IW = $clog2(NUM_WORKERS);
    localparam int CW = credit_width(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_CREDITS = CW'(FIFO_DEPTH - 1);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [NUM_WORKERS-1:0] eligible;
    logic [NUM_WORKERS-1:0] pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 any_eligible;
    logic [IW-1:0]        rr_ptr;
    logic                 grant;
    logic                 pop;

    // A worker acked this cycle still shows req with stale data; mask it out.
    assign eligible = wrk_req & ~wrk_ack;

    rr_pick #(.N(NUM_WORKERS)) u_pick (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any_valid  (any_eligible)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, GRANT: begin
                    if (grant) begin
                        state_next = GRANT;
                    end else if (any_eligible && credits == '0) begin
                        state_next = STALL;
                    end else begin
                        state_next = IDLE;
                    end
                end
                STALL: begin
                    if (!any_eligible) begin
                        state_next = IDLE;
                    end else if (pop || credits != '0) begin
                        state_next = GRANT;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output/decision logic: grant whenever allowed, pop only on a real read.
    always_comb begin
        grant = enable && (credits != '0) && any_eligible;
        pop   = fifo_r_cntrl && !fifo_empty;
        busy  = (state != IDLE);
    end

    // Registered write port, acks and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrk_ack      <= '0;
            fifo_w_cntrl <= 1'b0;
            fifo_data_in <= '0;
            rr_ptr       <= '0;
        end else begin
            wrk_ack      <= grant ? pick_onehot : '0;
            fifo_w_cntrl <= grant;
            if (grant) begin
                fifo_data_in <= wrk_data[pick_idx*BIT_WIDTH +: BIT_WIDTH];
                rr_ptr       <= (pick_idx == IW'(NUM_WORKERS - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    // Credit counter: grant consumes a slot, a real pop returns one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits <= MAX_CREDITS;
        end else begin
            case ({grant, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   if (credits != MAX_CREDITS) credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Saturating stall-cycle and per-worker grant counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            grant_cnt    <= '0;
        end else begin
            if (state == STALL && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            for (int i = 0; i < NUM_WORKERS; i++) begin
                if (grant && pick_onehot[i] &&
                    grant_cnt[i*STAT_WIDTH +: STAT_WIDTH] != '1) begin
                    grant_cnt[i*STAT_WIDTH +: STAT_WIDTH] <=
                        grant_cnt[i*STAT_WIDTH +: STAT_WIDTH] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a FIFO occupancy model and a
// scoreboard of expected (worker, data) writes.
module tb_fifo_write_arbiter;

    localparam int NW = 4;
    localparam int BW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [NW-1:0]   wrk_req;
    logic [NW*BW-1:0] wrk_data;
    logic [NW-1:0]   wrk_ack;
    logic            fifo_w_cntrl;
    logic [BW-1:0]   fifo_data_in;
    logic            fifo_r_cntrl;
    logic            fifo_empty;
    logic [4:0]      credits;
    logic            busy;

    int              checks   = 0;
    int              failures = 0;
    int              fifo_cnt = 0;
    logic            force_empty    = 1'b0;
    logic            force_nonempty = 1'b0;
    logic [BW-1:0]   wd   [NW];
    logic [BW-1:0]   pred [NW];
    int              exp_w [$];
    logic [BW-1:0]   exp_d [$];

    fifo_write_arbiter #(.NUM_WORKERS(NW), .BIT_WIDTH(BW), .FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .wrk_req      (wrk_req),
        .wrk_data     (wrk_data),
        .wrk_ack      (wrk_ack),
        .fifo_w_cntrl (fifo_w_cntrl),
        .fifo_data_in (fifo_data_in),
        .fifo_r_cntrl (fifo_r_cntrl),
        .fifo_empty   (fifo_empty),
        .credits      (credits),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        wrk_data = {wd[3], wd[2], wd[1], wd[0]};
    endtask

    task automatic push_exp(input int w);
        exp_w.push_back(w);
        exp_d.push_back(pred[w]);
        pred[w] = pred[w] + 1;
    endtask

    // One clock: update the FIFO model, then check any write against the scoreboard.
    task automatic tick();
        logic w_pre;
        logic p_pre;
        int   ew;
        logic [BW-1:0] ed;
        w_pre = fifo_w_cntrl;
        p_pre = fifo_r_cntrl && !fifo_empty;
        if (w_pre) check("fifo_not_full", 32'(fifo_cnt < 15), 32'd1);
        @(posedge clk);
        if (!rst_n) begin
            fifo_cnt = 0;
        end else begin
            if (w_pre) fifo_cnt++;
            if (p_pre && fifo_cnt > 0) fifo_cnt--;
        end
        #1;
        fifo_empty = force_empty ? 1'b1 : (force_nonempty ? 1'b0 : (fifo_cnt == 0));
        if (fifo_w_cntrl) begin
            if (exp_w.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                ew = exp_w.pop_front();
                ed = exp_d.pop_front();
                check("write_data", fifo_data_in, ed);
                check("write_ack", 32'(wrk_ack), 32'(1 << ew));
            end
        end else begin
            check("ack_idle", 32'(wrk_ack), 32'd0);
        end
        for (int i = 0; i < NW; i++) begin
            if (wrk_ack[i]) wd[i] = wd[i] + 1;
        end
        drive_data();
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        wrk_req      = '0;
        fifo_r_cntrl = 1'b0;
        fifo_empty   = 1'b1;
        for (int i = 0; i < NW; i++) begin
            wd[i]   = 32'hA000_0000 | (32'(i) << 16);
            pred[i] = wd[i];
        end
        drive_data();

        // Reset state
        tick();
        tick();
        check("rst_ack", 32'(wrk_ack), 32'd0);
        check("rst_wcntrl", 32'(fifo_w_cntrl), 32'd0);
        check("rst_data", fifo_data_in, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_credits", 32'(credits), 32'd15);
        rst_n = 1'b1;
        tick();

        // All four requesting, FIFO drained continuously: order 0,1,2,3,0,1,2,3
        fifo_r_cntrl = 1'b1;
        wrk_req = 4'b1111;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NW; i++) push_exp(i);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_burst_wcntrl", 32'(fifo_w_cntrl), 32'd1);
        end
        wrk_req = '0;
        repeat (20) tick();
        check("rr_all_written", 32'(exp_w.size()), 32'd0);
        check("rr_drain_credits", 32'(credits), 32'd15);
        check("rr_drain_busy", 32'(busy), 32'd0);

        // Single worker 2: one write every other cycle, data advancing each time
        wrk_req = 4'b0100;
        repeat (3) push_exp(2);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("single_pattern", 32'(fifo_w_cntrl), 32'((k % 2) == 0));
        end
        wrk_req = '0;
        repeat (20) tick();
        check("single_all_written", 32'(exp_w.size()), 32'd0);

        // No reads: exactly 15 writes, rr_ptr starts at 3 after worker 2's last grant
        fifo_r_cntrl = 1'b0;
        wrk_req = 4'b1111;
        for (int k = 0; k < 15; k++) begin
            push_exp((3 + k) % NW);
            tick();
            check("fill_credits", 32'(credits), 32'(14 - k));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_wcntrl", 32'(fifo_w_cntrl), 32'd0);
            check("stall_credits", 32'(credits), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        check("fill_all_written", 32'(exp_w.size()), 32'd0);

        // One pop from STALL: one grant to worker 2, then stall again
        push_exp(2);
        fifo_r_cntrl = 1'b1;
        tick();
        check("pop_credit_return", 32'(credits), 32'd1);
        fifo_r_cntrl = 1'b0;
        tick();
        check("pop_regrant_wcntrl", 32'(fifo_w_cntrl), 32'd1);
        check("pop_regrant_credits", 32'(credits), 32'd0);
        repeat (2) begin
            tick();
            check("restall_wcntrl", 32'(fifo_w_cntrl), 32'd0);
            check("restall_busy", 32'(busy), 32'd1);
        end
        check("pop_all_written", 32'(exp_w.size()), 32'd0);

        // Grant and pop in the same cycle at credits=7
        wrk_req = '0;
        fifo_r_cntrl = 1'b1;
        repeat (7) tick();
        check("pop7_credits", 32'(credits), 32'd7);
        wrk_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push_exp((3 + k) % NW);
            tick();
            check("grant_pop_credits", 32'(credits), 32'd7);
        end
        wrk_req = '0;
        fifo_r_cntrl = 1'b0;
        tick();
        check("hold_credits", 32'(credits), 32'd7);

        // Read strobe while FIFO reports empty: no credit return
        force_empty  = 1'b1;
        fifo_empty   = 1'b1;
        fifo_r_cntrl = 1'b1;
        repeat (2) tick();
        check("empty_pop_credits", 32'(credits), 32'd7);
        force_empty  = 1'b0;
        fifo_r_cntrl = 1'b0;
        fifo_empty   = (fifo_cnt == 0);

        // Reset mid-burst at credits=9
        fifo_r_cntrl = 1'b1;
        repeat (6) tick();
        check("pre_burst_credits", 32'(credits), 32'd13);
        fifo_r_cntrl = 1'b0;
        wrk_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push_exp((3 + k) % NW);
            tick();
        end
        check("midburst_credits", 32'(credits), 32'd9);
        check("midburst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_credits", 32'(credits), 32'd15);
        check("midrst_ack", 32'(wrk_ack), 32'd0);
        check("midrst_wcntrl", 32'(fifo_w_cntrl), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        push_exp(0);
        tick();
        check("post_rst_first_grant", 32'(wrk_ack), 32'd1);
        wrk_req = '0;
        fifo_r_cntrl = 1'b1;
        repeat (10) tick();
        check("final_credits", 32'(credits), 32'd15);

        // Pop at full credits with a non-empty flag: saturate, never wrap
        force_nonempty = 1'b1;
        fifo_empty     = 1'b0;
        repeat (2) tick();
        check("saturate_credits", 32'(credits), 32'd15);
        force_nonempty = 1'b0;
        fifo_r_cntrl   = 1'b0;
        tick();
        check("final_all_written", 32'(exp_w.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the pixel FIFO between NUM_WORKERS Mandelbrot workers. The FIFO sits between the workers and the VGA driver.
- Keeps a credit counter that mirrors FIFO occupancy, so no write is issued into a full FIFO.
- Accounts for writes still in flight that the FIFO full flag does not yet show.
- Sits in the top level between the worker array and the FIFO write side. It also taps the VGA read strobe to recover credits.

Parameters:
NUM_WORKERS, 4, number of requesting workers (2..16)
BIT_WIDTH, 32, width of one pixel result word; must match the FIFO
FIFO_DEPTH, 16, FIFO row count; usable credits = FIFO_DEPTH-1, because the FIFO flags full at count = FIFO_DEPTH-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset
enable  in  1  1 = grants allowed; 0 = no new grants
wrk_req  in  NUM_WORKERS  per-worker request; data held stable while req=1 and until ack
wrk_data  in  NUM_WORKERS*BIT_WIDTH  packed worker results; worker i occupies bits [i*BIT_WIDTH +: BIT_WIDTH]
wrk_ack  out  NUM_WORKERS  one-hot, one-cycle acceptance pulse
fifo_w_cntrl  out  1  FIFO write strobe, registered
fifo_data_in  out  BIT_WIDTH  FIFO write data, registered
fifo_r_cntrl  in  1  VGA-side FIFO read strobe (tap)
fifo_empty  in  1  FIFO empty flag
credits  out  $clog2(FIFO_DEPTH)+1  free FIFO slots as seen by the arbiter
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wrk_ack=0, fifo_w_cntrl=0, fifo_data_in=0, busy=0.
  - credits=FIFO_DEPTH-1, rr_ptr=0 (worker 0 highest priority), state=IDLE.
  - Reset mid-transfer drops any pending write. The FIFO receives the same reset (inverted at top), so the two stay consistent.
- Eligibility: worker i is eligible iff wrk_req[i]=1 and wrk_ack[i]=0 this cycle. The ack mask stops a worker's stale data from being re-granted.
- Grant condition: enable=1, credits>0 and at least one eligible worker.
  - Winner = first eligible worker at or after rr_ptr, searching upward with wrap-around.
- On a grant at edge k:
  - wrk_ack[winner]=1, fifo_w_cntrl=1, fifo_data_in=wrk_data[winner]; all three are registered and valid during cycle k..k+1.
  - rr_ptr = winner+1 mod NUM_WORKERS.
  - The FIFO samples the write at edge k+1.
- No grant: wrk_ack=0 and fifo_w_cntrl=0 on the next cycle; fifo_data_in holds its last value.
- Throughput:
  - With two or more requesters: one write per cycle.
  - With a single requester: one write every 2 cycles (ack mask).
- Credits:
  - Decrement by 1 on a grant.
  - Increment by 1 when fifo_r_cntrl=1 and fifo_empty=0 (a real pop).
  - Grant and pop in the same cycle: no change.
  - Pop at credits=FIFO_DEPTH-1: saturate (error case, never wraps).
- FSM (registered):
  - IDLE: no eligible worker or enable=0. Go to GRANT when the grant condition holds; go to STALL when eligible workers exist, enable=1 and credits=0.
  - GRANT: a grant is issued each cycle. Stay while the grant condition holds. Go to STALL when credits reach 0 with a request pending. Go to IDLE when no worker is eligible.
  - STALL: no grants. Go to GRANT on the first credit return while a request is pending. Go to IDLE if all requests drop.
  - enable=0 in any state: go to IDLE next edge. A write already registered still completes.
- Invariant: credits + FIFO count + in-flight writes = FIFO_DEPTH-1. The FIFO must never see w_cntrl=1 while full=1.

Optional Feature:
ARB_STATS_EN
- Defined: adds output stall_cycles [15:0] and outputs grant_cnt [NUM_WORKERS*16-1:0].
  - stall_cycles counts cycles spent in STALL.
  - grant_cnt holds per-worker grant counters.
  - All counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - state encoding (IDLE=2'd0, GRANT=2'd1, STALL=2'd2)
  - credit-width function
  - STAT_WIDTH=16
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: one-hot winner, winner index, any_valid.
  - Instantiated once.

Test Plan:
- Reset, then wrk_req=4'b1111 with distinct data, FIFO drained continuously -> grants in order 0,1,2,3,0,... on consecutive cycles; fifo_data_in matches the granted worker; ack one-hot.
- Single worker 2 holding req high and updating data after each ack -> fifo_w_cntrl pattern 1,0,1,0; no duplicate word written.
- No reads, all 4 workers requesting -> exactly 15 writes; credits 15 to 0; state=STALL; fifo_w_cntrl stays 0 while FIFO full=1.
- From STALL, one read pop -> credits goes 0 to 1; exactly one further grant, to the next worker in round-robin order; back to STALL.
- Grant and pop in the same cycle at credits=7 -> credits stays 7; pop with fifo_empty=1 -> credits unchanged.
- rst_n=0 mid-burst (credits=9, state GRANT) -> next cycle credits=15, acks=0, fifo_w_cntrl=0, rr_ptr=0, state IDLE.
